field_gen_engine: RTL and testbench
===================================

# field_gen_engine

Multi-lane, multi-generation Game of Life field iterator. It is the parametrised successor of the single-cell `next_field_iter`. It rasters the double-buffered field LANES cells per cycle and tolerates read stalls via `i_rd_valid`. It runs a requested number of generations back-to-back, swapping read/write buffers between generations, and reports live-cell population per generation. It sits between the field memories and the display/control FSM.

## Interface
Parameters:
- `FIELD_W`, 64, field width in cells; must be a multiple of LANES
- `FIELD_H`, 48, field height in cells
- `LANES`, 4, cells processed per cycle; power of two, ≥1
- `GEN_W`, 16, width of the generation counter
- Derived: X_ADR_SIZE=$clog2(FIELD_W), Y_ADR_SIZE=$clog2(FIELD_H), POP_W=$clog2(FIELD_W*FIELD_H+1)

Ports:
- `clk` in 1: the single clock
- `rst_n` in 1: reset, asynchronous and active-low
- `i_go` in 1: start a run; sampled only in IDLE
- `i_gens` in GEN_W: number of generations to run; 0 is treated as 1
- `i_abort` in 1: stop at the end of the current generation
- `i_rd_valid` in 1: read data for `o_next_*` is valid at this edge
- `i_next_cell_state` in LANES: bit i is the state of cell (o_next_x+i, o_next_y)
- `i_next_nbrs` in LANES*NEIGHBOURS_CNT: lane i neighbours at [i*NEIGHBOURS_CNT +: NEIGHBOURS_CNT]
- `o_is_simulating` out 1: high in RUN and SWAP
- `o_next_x` / `o_next_y` out X_ADR_SIZE / Y_ADR_SIZE: read address of the lane-0 cell
- `o_cur_x` / `o_cur_y` out X_ADR_SIZE / Y_ADR_SIZE: write address of the lane-0 cell
- `o_wr_en` out 1: `o_new_cur_cell_state` is valid for the write address
- `o_new_cur_cell_state` out LANES: new states, combinational from registered data
- `o_cur_read_field` out field_t: buffer currently being read
- `o_gen_done` out 1: one-cycle pulse per completed generation
- `o_gens_left` out GEN_W: generations remaining in the current run
- `o_population` out POP_W: live count of the last completed generation
- `o_stable` out 1: see Configuration

## Operation
States: GS_IDLE, GS_RUN, GS_SWAP.

- **IDLE**
  - `o_next_*` = (0,0) and `o_wr_en` = 0.
  - When `i_go` is high: load gens_left from `i_gens` (0→1), clear the population accumulator and change flag, go to RUN.
- **RUN, edge with `i_rd_valid`=1**
  - Register the lane data.
  - cur ← next.
  - next advances x by LANES. When x passes FIELD_W-LANES it wraps to 0 and y increments; y wraps from FIELD_H-1 to 0.
  - `o_wr_en` ← 1.
  - If the sampled group was (FIELD_W-LANES, FIELD_H-1), go to SWAP.
- **RUN, edge with `i_rd_valid`=0**
  - Addresses and registered data are held; `o_wr_en` ← 0.
- **SWAP** (one cycle)
  - `o_wr_en` is high for the last group; no fetch happens.
  - At the closing edge:
    - `o_cur_read_field` toggles.
    - gens_left decrements.
    - `o_population` ← accumulator + last group, then the accumulator clears.
    - `o_gen_done` ← 1 for one cycle.
  - Next state is IDLE if gens_left hits 0, abort is latched, or stable is detected; otherwise RUN.
- **Population accumulator:** adds popcount(`o_new_cur_cell_state`) on every `o_wr_en` cycle.
- **`i_abort`:** latched while in RUN/SWAP and cleared on entry to IDLE. The generation always completes, so the buffers stay consistent.
- **`i_go` outside IDLE:** ignored.
- **Reset (any time, including mid-run):**
  - State IDLE; all counters and outputs 0.
  - `o_cur_read_field` = FIELD_A.
  - `o_new_cur_cell_state` reflects zeroed registers.

## Timing
- Read latency: data for `o_next_*` is expected at the next rising edge.
- Write latency: `o_new_cur_cell_state` for `o_cur_*` is valid in the cycle after the sampling edge.
- Without stalls, a generation takes FIELD_W*FIELD_H/LANES + 1 cycles, measured from the first RUN edge to the SWAP exit.
- `o_is_simulating` falls, and `o_cur_read_field` toggles, on the same edge that raises `o_gen_done`.
- Consecutive generations resume fetching (0,0) immediately after SWAP.

## Configuration
Macro: `GOL_STABLE_DETECT_EN`.
- **Defined:**
  - A change flag sets on any written lane whose new state differs from its registered old state.
  - At SWAP, if the flag is clear, the run ends early and `o_stable` is set.
  - `o_stable` stays set until the next `i_go` or reset.
- **Undefined:** `o_stable` is tied 0 and all requested generations run.

## Structure
- **Package `defs`:**
  - field_t (FIELD_A/FIELD_B) and NEIGHBOURS_CNT, both existing.
  - New gen_state_t enum.
- **Existing `next_cell_state`:** instantiated LANES times.
- **New sub-module `field_addr_cnt`:** raster x/y counter with step LANES, enable, wrap and last-group flag.

## Test plan
Configuration for all scenarios: FIELD_W=8, FIELD_H=4, LANES=2.
1. **Reset:** all outputs 0, `o_cur_read_field`=FIELD_A, `o_is_simulating`=0.
2. **Single generation:** `i_go`, `i_gens`=1, `i_rd_valid`=1 → `o_next` sequence (0,0),(2,0)…(6,3),(0,0). Then 16 `o_wr_en` cycles, one SWAP, `o_gen_done` 17 cycles after the first RUN edge, field=FIELD_B.
3. **Stall:** `i_rd_valid`=0 for 3 cycles at (4,1) → addresses held, `o_wr_en` low 3 cycles, `o_gen_done` 3 cycles later; new states match the reference `next_cell_state`.
4. **Multi-generation:** `i_gens`=3 → 3 `o_gen_done` pulses 17 cycles apart, `o_gens_left` 3→2→1→0, field ends FIELD_B. `i_gens`=0 behaves as 1.
5. **Population and abort:**
   - All cells alive with 3 live neighbours → `o_population`=32.
   - `i_abort` mid-generation 2 of 5 → generation 2 completes, IDLE, `o_gens_left`=3.
6. **Stable detect (`GOL_STABLE_DETECT_EN`):** all-zero field, `i_gens`=10 → stops after generation 1, `o_stable`=1, `o_gens_left`=9. Without the macro, all 10 generations run.

Source files
------------

// File: rtl/field_gen_engine_pkg.sv
// Shared types for the Game of Life field engine: buffer select, neighbour count
// and the generation sequencer states.
package defs;

  localparam int NEIGHBOURS_CNT = 8;

  typedef enum logic {
    FIELD_A = 1'b0,
    FIELD_B = 1'b1
  } field_t;

  typedef enum logic [1:0] {
    GS_IDLE,
    GS_RUN,
    GS_SWAP
  } gen_state_t;

endpackage

// File: rtl/field_gen_engine_addr_cnt.sv
// Raster address counter for the field: x steps by STEP cells, wraps into the
// next row, y wraps at the bottom; last flags the final group of the field.
module field_addr_cnt #(
  parameter int W    = 64,
  parameter int H    = 48,
  parameter int STEP = 4,
  localparam int XW  = $clog2(W),
  localparam int YW  = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] X_LAST = XW'(W - STEP);
  localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

  assign last = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + XW'(STEP);
      end
    end
  end

endmodule

// File: rtl/next_cell_state.sv
// Single-cell Game of Life rule: birth on exactly 3 live neighbours,
// survival on 2 or 3.
module next_cell_state
  import defs::*;
(
  input  logic                      cell_state,
  input  logic [NEIGHBOURS_CNT-1:0] nbrs,
  output logic                      new_state
);

  logic [3:0] live_cnt;

  assign live_cnt  = 4'($countones(nbrs));
  assign new_state = (live_cnt == 4'd3) || (cell_state && (live_cnt == 4'd2));

endmodule

// File: rtl/field_gen_engine.sv
// Multi-lane, multi-generation Game of Life field iterator over a double-buffered
// field. Optional early stop on a stable field: define GOL_STABLE_DETECT_EN.
module field_gen_engine
  import defs::*;
#(
  parameter int FIELD_W     = 64,
  parameter int FIELD_H     = 48,
  parameter int LANES       = 4,
  parameter int GEN_W       = 16,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H),
  localparam int POP_W      = $clog2(FIELD_W * FIELD_H + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_go,
  input  logic [GEN_W-1:0]                  i_gens,
  input  logic                              i_abort,
  input  logic                              i_rd_valid,
  input  logic [LANES-1:0]                  i_next_cell_state,
  input  logic [LANES*NEIGHBOURS_CNT-1:0]   i_next_nbrs,
  output logic                              o_is_simulating,
  output logic [X_ADR_SIZE-1:0]             o_next_x,
  output logic [Y_ADR_SIZE-1:0]             o_next_y,
  output logic [X_ADR_SIZE-1:0]             o_cur_x,
  output logic [Y_ADR_SIZE-1:0]             o_cur_y,
  output logic                              o_wr_en,
  output logic [LANES-1:0]                  o_new_cur_cell_state,
  output field_t                            o_cur_read_field,
  output logic                              o_gen_done,
  output logic [GEN_W-1:0]                  o_gens_left,
  output logic [POP_W-1:0]                  o_population,
  output logic                              o_stable
);

  gen_state_t                      state, state_nxt;
  logic [LANES-1:0]                old_cell;
  logic [LANES*NEIGHBOURS_CNT-1:0] old_nbrs;
  logic [POP_W-1:0]                pop_acc, lane_pop;
  logic [GEN_W-1:0]                gens_dec;
  logic                            abort_q, fetch, last_grp, run_end;

  assign fetch           = (state == GS_RUN) && i_rd_valid;
  assign o_is_simulating = (state != GS_IDLE);
  assign lane_pop        = POP_W'($countones(o_new_cur_cell_state));
  assign gens_dec        = o_gens_left - 1'b1;

  field_addr_cnt #(.W(FIELD_W), .H(FIELD_H), .STEP(LANES)) u_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (fetch),
    .clr   (state == GS_IDLE),
    .x     (o_next_x),
    .y     (o_next_y),
    .last  (last_grp)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    next_cell_state u_cell (
      .cell_state (old_cell[l]),
      .nbrs       (old_nbrs[l*NEIGHBOURS_CNT +: NEIGHBOURS_CNT]),
      .new_state  (o_new_cur_cell_state[l])
    );
  end

`ifdef GOL_STABLE_DETECT_EN
  logic changed_q, lane_diff, stable_hit, stable_q;

  // The last group is still on the write port during SWAP, so fold it in live.
  assign lane_diff  = |(o_new_cur_cell_state ^ old_cell);
  assign stable_hit = !(changed_q || lane_diff);
  assign o_stable   = stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_q <= 1'b0;
      stable_q  <= 1'b0;
    end else begin
      case (state)
        GS_IDLE: if (i_go) begin
          changed_q <= 1'b0;
          stable_q  <= 1'b0;
        end
        GS_RUN:  if (o_wr_en) changed_q <= changed_q | lane_diff;
        GS_SWAP: begin
          changed_q <= 1'b0;
          stable_q  <= stable_q | stable_hit;
        end
        default: ;
      endcase
    end
  end
`else
  logic stable_hit;

  assign stable_hit = 1'b0;
  assign o_stable   = 1'b0;
`endif

  assign run_end = (gens_dec == '0) || abort_q || i_abort || stable_hit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GS_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default first, so no path leaves state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      GS_IDLE: if (i_go) state_nxt = GS_RUN;
      GS_RUN:  if (fetch && last_grp) state_nxt = GS_SWAP;
      GS_SWAP: state_nxt = run_end ? GS_IDLE : GS_RUN;
      default: state_nxt = GS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      old_cell         <= '0;
      old_nbrs         <= '0;
      o_cur_x          <= '0;
      o_cur_y          <= '0;
      o_wr_en          <= 1'b0;
      o_cur_read_field <= FIELD_A;
      o_gen_done       <= 1'b0;
      o_gens_left      <= '0;
      o_population     <= '0;
      pop_acc          <= '0;
      abort_q          <= 1'b0;
    end else begin
      o_gen_done <= 1'b0;
      o_wr_en    <= fetch;
      if (fetch) begin
        old_cell <= i_next_cell_state;
        old_nbrs <= i_next_nbrs;
        o_cur_x  <= o_next_x;
        o_cur_y  <= o_next_y;
      end
      case (state)
        GS_IDLE: begin
          abort_q <= 1'b0;
          if (i_go) begin
            o_gens_left <= (i_gens == '0) ? GEN_W'(1) : i_gens;
            pop_acc     <= '0;
          end
        end
        GS_RUN: begin
          if (i_abort) abort_q <= 1'b1;
          if (o_wr_en) pop_acc <= pop_acc + lane_pop;
        end
        GS_SWAP: begin
          o_cur_read_field <= (o_cur_read_field == FIELD_A) ? FIELD_B : FIELD_A;
          o_gens_left      <= gens_dec;
          o_population     <= pop_acc + lane_pop;
          pop_acc          <= '0;
          o_gen_done       <= 1'b1;
          abort_q          <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_field_gen_engine.sv
// Bench for field_gen_engine: the bench owns both field buffers, serves reads,
// captures writes and compares each generation against a whole-field life model.
module tb_field_gen_engine;
  import defs::*;

  localparam int FIELD_W = 8;
  localparam int FIELD_H = 4;
  localparam int LANES   = 2;
  localparam int GEN_W   = 16;
  localparam int NB      = NEIGHBOURS_CNT;
  localparam int XS      = $clog2(FIELD_W);
  localparam int YS      = $clog2(FIELD_H);
  localparam int POP_W   = $clog2(FIELD_W * FIELD_H + 1);
  localparam int GROUPS  = FIELD_W * FIELD_H / LANES;
  localparam int GPR     = FIELD_W / LANES;
`ifdef GOL_STABLE_DETECT_EN
  localparam bit STABLE_EN = 1'b1;
`else
  localparam bit STABLE_EN = 1'b0;
`endif

  logic                  clk, rst_n, i_go, i_abort, i_rd_valid;
  logic [GEN_W-1:0]      i_gens;
  logic [LANES-1:0]      i_next_cell_state;
  logic [LANES*NB-1:0]   i_next_nbrs;
  logic                  o_is_simulating, o_wr_en, o_gen_done, o_stable;
  logic [XS-1:0]         o_next_x, o_cur_x;
  logic [YS-1:0]         o_next_y, o_cur_y;
  logic [LANES-1:0]      o_new_cur_cell_state;
  field_t                o_cur_read_field;
  logic [GEN_W-1:0]      o_gens_left;
  logic [POP_W-1:0]      o_population;

  logic fld [2][FIELD_H][FIELD_W];
  bit   force3;
  int   model_rf;
  int   n_checks, n_fail;
  int   nd, fd;

  field_gen_engine #(.FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .LANES(LANES), .GEN_W(GEN_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_go                 (i_go),
    .i_gens               (i_gens),
    .i_abort              (i_abort),
    .i_rd_valid           (i_rd_valid),
    .i_next_cell_state    (i_next_cell_state),
    .i_next_nbrs          (i_next_nbrs),
    .o_is_simulating      (o_is_simulating),
    .o_next_x             (o_next_x),
    .o_next_y             (o_next_y),
    .o_cur_x              (o_cur_x),
    .o_cur_y              (o_cur_y),
    .o_wr_en              (o_wr_en),
    .o_new_cur_cell_state (o_new_cur_cell_state),
    .o_cur_read_field     (o_cur_read_field),
    .o_gen_done           (o_gen_done),
    .o_gens_left          (o_gens_left),
    .o_population         (o_population),
    .o_stable             (o_stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cell_at(input int f, input int y, input int x);
    if (force3) return 1'b1;
    return fld[f][(y + FIELD_H) % FIELD_H][(x + FIELD_W) % FIELD_W];
  endfunction

  function automatic logic [NB-1:0] nbrs_at(input int f, input int y, input int x);
    logic [NB-1:0] v;
    int k;
    v = '0;
    k = 0;
    if (force3) return NB'(3'b111);
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dy != 0 || dx != 0) begin
          v[k] = fld[f][(y + dy + FIELD_H) % FIELD_H][(x + dx + FIELD_W) % FIELD_W];
          k++;
        end
    return v;
  endfunction

  function automatic logic life(input int f, input int y, input int x);
    int n;
    n = $countones(nbrs_at(f, y, x));
    return cell_at(f, y, x) ? (n == 2 || n == 3) : (n == 3);
  endfunction

  // Raster group index -> packed {y, x} of its lane-0 cell.
  function automatic logic [31:0] grp(input int idx);
    int gx, gy;
    gx = (idx % GPR) * LANES;
    gy = (idx / GPR) % FIELD_H;
    return 32'((gy << XS) | gx);
  endfunction

  // Field memory: answers the read address, stores the written lanes.
  always @(negedge clk) begin
    int rb;
    rb = (o_cur_read_field == FIELD_B) ? 1 : 0;
    for (int l = 0; l < LANES; l++) begin
      i_next_cell_state[l]      = cell_at(rb, int'(o_next_y), int'(o_next_x) + l);
      i_next_nbrs[l*NB +: NB]   = nbrs_at(rb, int'(o_next_y), int'(o_next_x) + l);
      if (o_wr_en)
        fld[1-rb][int'(o_cur_y) % FIELD_H][(int'(o_cur_x) + l) % FIELD_W] = o_new_cur_cell_state[l];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_field(input bit zero);
    for (int y = 0; y < FIELD_H; y++)
      for (int x = 0; x < FIELD_W; x++)
        fld[model_rf][y][x] = zero ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  task automatic run_gens(input int gens, input int stall_pct, input int stall_grp,
                          input int abort_cyc, output int n_done, output int first_done);
    int gl, fc, cyc, stall_left, pop, wb;
    bit running, aborted, fetched, swap_edge, stable_exp;
    logic [FIELD_W-1:0] erow, orow;
    gl = (gens == 0) ? 1 : gens;
    n_done = 0; first_done = 0; aborted = 0; stall_left = 3;
    i_gens = GEN_W'(gens);
    i_go = 1'b1;
    tick();
    i_go = 1'b0;
    i_gens = '1;
    running = 1; fc = 0; cyc = 0;
    chk("gens_left_load", 32'(o_gens_left), 32'(gl));
    chk("stable_clear", 32'(o_stable), 32'(0));
    while (running && cyc < 4000) begin
      i_rd_valid = ($urandom_range(0, 99) >= stall_pct);
      if (fc == stall_grp && stall_left > 0) begin
        i_rd_valid = 1'b0;
        stall_left--;
      end
      i_abort = (cyc == abort_cyc);
      if (i_abort) aborted = 1;
      i_go = (cyc == 5);
      fetched = 0; swap_edge = 0;
      if (fc < GROUPS) begin
        if (i_rd_valid) begin fc++; fetched = 1; end
      end else swap_edge = 1;
      tick();
      cyc++;
      i_go = 1'b0;
      i_abort = 1'b0;
      chk("wr_en", 32'(o_wr_en), 32'(fetched));
      chk("gen_done", 32'(o_gen_done), 32'(swap_edge));
      if (fetched) chk("cur_addr", 32'({o_cur_y, o_cur_x}), grp(fc - 1));
      if (swap_edge) begin
        n_done++;
        if (n_done == 1) first_done = cyc;
        gl--;
        wb = 1 - model_rf;
        pop = 0;
        stable_exp = 1;
        for (int y = 0; y < FIELD_H; y++) begin
          for (int x = 0; x < FIELD_W; x++) begin
            erow[x] = life(model_rf, y, x);
            orow[x] = fld[wb][y][x];
            if (erow[x] !== cell_at(model_rf, y, x)) stable_exp = 0;
            pop += int'(erow[x]);
          end
          chk($sformatf("gen%0d_row%0d", n_done, y), 32'(orow), 32'(erow));
        end
        stable_exp = stable_exp && STABLE_EN;
        chk("population", 32'(o_population), 32'(pop));
        chk("gens_left", 32'(o_gens_left), 32'(gl));
        chk("stable", 32'(o_stable), 32'(stable_exp));
        model_rf = wb;
        fc = 0;
        if (gl == 0 || aborted || stable_exp) running = 0;
      end
      chk("read_field", 32'(o_cur_read_field), 32'(model_rf));
      chk("is_simulating", 32'(o_is_simulating), 32'(running));
      chk("next_addr", 32'({o_next_y, o_next_x}), running ? grp(fc) : 32'(0));
    end
    chk("run_bounded", 32'(running), 32'(0));
  endtask

  initial begin
    n_checks = 0; n_fail = 0; model_rf = 0; force3 = 0;
    rst_n = 1'b0; i_go = 1'b0; i_gens = '0; i_abort = 1'b0; i_rd_valid = 1'b0;
    for (int f = 0; f < 2; f++) begin
      model_rf = f;
      fill_field(1'b1);
    end
    model_rf = 0;
    #12;
    chk("rst_is_sim", 32'(o_is_simulating), 32'(0));
    chk("rst_wr_en", 32'(o_wr_en), 32'(0));
    chk("rst_next", 32'({o_next_y, o_next_x}), 32'(0));
    chk("rst_cur", 32'({o_cur_y, o_cur_x}), 32'(0));
    chk("rst_field", 32'(o_cur_read_field), 32'(FIELD_A));
    chk("rst_done", 32'(o_gen_done), 32'(0));
    chk("rst_gens_left", 32'(o_gens_left), 32'(0));
    chk("rst_pop", 32'(o_population), 32'(0));
    chk("rst_stable", 32'(o_stable), 32'(0));
    chk("rst_new_state", 32'(o_new_cur_cell_state), 32'(0));
    tick();
    rst_n = 1'b1;
    tick();

    fill_field(1'b0);
    run_gens(1, 0, -1, -1, nd, fd);
    chk("single_done_cnt", 32'(nd), 32'(1));
    chk("single_latency", 32'(fd), 32'(GROUPS + 1));
    chk("single_field", 32'(o_cur_read_field), 32'(FIELD_B));

    fill_field(1'b0);
    run_gens(1, 0, 6, -1, nd, fd);
    chk("stall_latency", 32'(fd), 32'(GROUPS + 4));

    fill_field(1'b0);
    run_gens(3, 0, -1, -1, nd, fd);
    chk("multi_done_cnt", 32'(nd), 32'(3));
    chk("multi_gens_left", 32'(o_gens_left), 32'(0));
    chk("multi_field", 32'(o_cur_read_field), 32'(FIELD_B));

    fill_field(1'b0);
    run_gens(0, 0, -1, -1, nd, fd);
    chk("zero_gens_done_cnt", 32'(nd), 32'(1));

    fill_field(1'b0);
    run_gens(4, 30, -1, -1, nd, fd);
    chk("rand_stall_done_cnt", 32'(nd), 32'(STABLE_EN ? nd : 4));

    force3 = 1;
    run_gens(1, 0, -1, -1, nd, fd);
    chk("pop_all_alive", 32'(o_population), 32'(FIELD_W * FIELD_H));
    force3 = 0;

    fill_field(1'b0);
    run_gens(5, 0, -1, GROUPS + 8, nd, fd);
    chk("abort_done_cnt", 32'(nd), 32'(2));
    chk("abort_gens_left", 32'(o_gens_left), 32'(3));

    fill_field(1'b1);
    run_gens(10, 0, -1, -1, nd, fd);
    chk("stable_done_cnt", 32'(nd), 32'(STABLE_EN ? 1 : 10));
    chk("stable_flag", 32'(o_stable), 32'(STABLE_EN));
    chk("stable_gens_left", 32'(o_gens_left), 32'(STABLE_EN ? 9 : 0));

    fill_field(1'b0);
    i_gens = 16'd2;
    i_go = 1'b1;
    tick();
    i_go = 1'b0;
    i_rd_valid = 1'b1;
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_is_sim", 32'(o_is_simulating), 32'(0));
    chk("midrst_wr_en", 32'(o_wr_en), 32'(0));
    chk("midrst_next", 32'({o_next_y, o_next_x}), 32'(0));
    chk("midrst_gens_left", 32'(o_gens_left), 32'(0));
    chk("midrst_field", 32'(o_cur_read_field), 32'(FIELD_A));
    chk("midrst_new_state", 32'(o_new_cur_cell_state), 32'(0));
    model_rf = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(o_is_simulating), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
